// File: rtl/block_memory_looper.sv
// Block sequencer: walks an N0 x N1 grid of blocks in row-major order and
// broadcasts each block's compute offset plus three linear memory offsets
// over four independent rdy/ack channels. Advances once every channel has
// taken the current block, then stops with all rdy low after the last block.
module block_memory_looper #(
    parameter int BW      = 16,
    parameter int N0      = 3,
    parameter int N1      = 2,
    parameter int BSIZE0  = 8,
    parameter int BSIZE1  = 4,
    parameter int PITCH   = 64,
    parameter int I0_BASE = 0,
    parameter int I1_BASE = 1024,
    parameter int O_BASE  = 2048
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          bofs_rdy,
    input  logic          bofs_ack,
    output logic [BW-1:0] bofs0,
    output logic [BW-1:0] bofs1,
    output logic          i0_mofs_rdy,
    input  logic          i0_mofs_ack,
    output logic [BW-1:0] i0_mofs,
    output logic          i1_mofs_rdy,
    input  logic          i1_mofs_ack,
    output logic [BW-1:0] i1_mofs,
    output logic          o_mofs_rdy,
    input  logic          o_mofs_ack,
    output logic [BW-1:0] o_mofs
);

    localparam int IW0 = (N0 > 1) ? $clog2(N0) : 1;
    localparam int IW1 = (N1 > 1) ? $clog2(N1) : 1;
    localparam logic [IW0-1:0] IDX0_LAST = IW0'(N0 - 1);
    localparam logic [IW1-1:0] IDX1_LAST = IW1'(N1 - 1);

    // Channel bit order: 0 = block offset, 1 = input 0, 2 = input 1, 3 = output.
    logic [IW0-1:0] idx0_q, idx0_d;
    logic [IW1-1:0] idx1_q, idx1_d;
    logic [3:0]     pend_q, pend_d;
    logic           done_q, done_d;

    logic [3:0]     ack_vec;
    logic [3:0]     rdy_vec;
    logic [3:0]     remain;
    logic           advance;
    logic           last_blk;

    assign ack_vec  = {o_mofs_ack, i1_mofs_ack, i0_mofs_ack, bofs_ack};
    assign rdy_vec  = pend_q & {4{~done_q}};
    // Channels still owed the current block after this cycle's transfers.
    assign remain   = rdy_vec & ~ack_vec;
    // The edge where the last outstanding channel transfers moves the grid on.
    assign advance  = (rdy_vec != 4'b0000) && (remain == 4'b0000);
    assign last_blk = (idx0_q == IDX0_LAST) && (idx1_q == IDX1_LAST);

    assign bofs_rdy    = rdy_vec[0];
    assign i0_mofs_rdy = rdy_vec[1];
    assign i1_mofs_rdy = rdy_vec[2];
    assign o_mofs_rdy  = rdy_vec[3];

    // Next-state: clear pending flags on transfer, re-arm all four on advance.
    always_comb begin
        idx0_d = idx0_q;
        idx1_d = idx1_q;
        pend_d = remain;
        done_d = done_q;
        if (advance) begin
            if (last_blk) begin
                done_d = 1'b1;
                pend_d = 4'b0000;
            end else begin
                pend_d = 4'b1111;
                if (idx0_q == IDX0_LAST) begin
                    idx0_d = '0;
                    idx1_d = idx1_q + 1'b1;
                end else begin
                    idx0_d = idx0_q + 1'b1;
                end
            end
        end
    end

    // State register; reset re-presents block (0,0) on every channel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx0_q <= '0;
            idx1_q <= '0;
            pend_q <= 4'b1111;
            done_q <= 1'b0;
        end else begin
            idx0_q <= idx0_d;
            idx1_q <= idx1_d;
            pend_q <= pend_d;
            done_q <= done_d;
        end
    end

    // Offsets are pure functions of the indices, so they are stable while rdy.
    logic [BW-1:0] base_term;
    assign bofs0     = BW'(idx0_q) * BW'(BSIZE0);
    assign bofs1     = BW'(idx1_q) * BW'(BSIZE1);
    assign base_term = bofs1 * BW'(PITCH) + bofs0;
    assign i0_mofs   = BW'(I0_BASE) + base_term;
    assign i1_mofs   = BW'(I1_BASE) + base_term;
    assign o_mofs    = BW'(O_BASE) + base_term;

endmodule

// File: tb/tb_block_memory_looper.sv
// Testbench for block_memory_looper: per-channel transfer counters form the
// reference; the block every channel should present is the minimum count.
module tb_block_memory_looper;

    localparam int BW = 16, N0 = 3, N1 = 2, BSIZE0 = 8, BSIZE1 = 4, PITCH = 64;
    localparam int I0_BASE = 0, I1_BASE = 1024, O_BASE = 2048;
    localparam int NBLK = N0 * N1;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          bofs_rdy, i0_mofs_rdy, i1_mofs_rdy, o_mofs_rdy;
    logic          bofs_ack, i0_mofs_ack, i1_mofs_ack, o_mofs_ack;
    logic [BW-1:0] bofs0, bofs1, i0_mofs, i1_mofs, o_mofs;

    always #5 clk = ~clk;

    block_memory_looper #(
        .BW(BW), .N0(N0), .N1(N1), .BSIZE0(BSIZE0), .BSIZE1(BSIZE1),
        .PITCH(PITCH), .I0_BASE(I0_BASE), .I1_BASE(I1_BASE), .O_BASE(O_BASE)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .bofs_rdy(bofs_rdy), .bofs_ack(bofs_ack), .bofs0(bofs0), .bofs1(bofs1),
        .i0_mofs_rdy(i0_mofs_rdy), .i0_mofs_ack(i0_mofs_ack), .i0_mofs(i0_mofs),
        .i1_mofs_rdy(i1_mofs_rdy), .i1_mofs_ack(i1_mofs_ack), .i1_mofs(i1_mofs),
        .o_mofs_rdy(o_mofs_rdy), .o_mofs_ack(o_mofs_ack), .o_mofs(o_mofs)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt[4];          // transfers completed per channel since last reset
    logic [3:0] exp_rdy; // channels the model expects ready this cycle

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cur_blk();
        int m = cnt[0];
        for (int c = 1; c < 4; c++) if (cnt[c] < m) m = cnt[c];
        return m;
    endfunction

    function automatic int lin_ofs(input int b, input int base);
        return ((b / N0) * BSIZE1 * PITCH + (b % N0) * BSIZE0 + base) % (1 << BW);
    endfunction

    // Sample at the falling edge and compare every channel to the model.
    task automatic sample();
        int b;
        @(negedge clk);
        b = cur_blk();
        for (int c = 0; c < 4; c++) exp_rdy[c] = (cnt[c] == b) && (b < NBLK);
        check_eq("bofs_rdy", {31'd0, bofs_rdy},    {31'd0, exp_rdy[0]});
        check_eq("i0_rdy",   {31'd0, i0_mofs_rdy}, {31'd0, exp_rdy[1]});
        check_eq("i1_rdy",   {31'd0, i1_mofs_rdy}, {31'd0, exp_rdy[2]});
        check_eq("o_rdy",    {31'd0, o_mofs_rdy},  {31'd0, exp_rdy[3]});
        if (exp_rdy[0]) begin
            check_eq("bofs0", {16'd0, bofs0}, (b % N0) * BSIZE0);
            check_eq("bofs1", {16'd0, bofs1}, (b / N0) * BSIZE1);
        end
        if (exp_rdy[1]) check_eq("i0_mofs", {16'd0, i0_mofs}, lin_ofs(b, I0_BASE));
        if (exp_rdy[2]) check_eq("i1_mofs", {16'd0, i1_mofs}, lin_ofs(b, I1_BASE));
        if (exp_rdy[3]) check_eq("o_mofs",  {16'd0, o_mofs},  lin_ofs(b, O_BASE));
    endtask

    // Drive inputs for the coming edge and advance the model accordingly.
    task automatic drive(input logic rst, input logic [3:0] ack);
        i_rst       = rst;
        bofs_ack    = ack[0];
        i0_mofs_ack = ack[1];
        i1_mofs_ack = ack[2];
        o_mofs_ack  = ack[3];
        $display("cyc t=%0t rst=%0b ack=%b blk=%0d rdy=%b", $time, rst, ack, cur_blk(), exp_rdy);
        for (int c = 0; c < 4; c++) begin
            if (rst) cnt[c] = 0;
            else if (exp_rdy[c] && ack[c]) cnt[c]++;
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] ack);
        sample();
        drive(rst, ack);
    endtask

    int i0_tbl[6] = '{0, 8, 16, 256, 264, 272};
    int guard;

    initial begin
        i_rst = 1'b1;
        {bofs_ack, i0_mofs_ack, i1_mofs_ack, o_mofs_ack} = 4'b0000;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        repeat (2) @(negedge clk);
        // Held reset: block (0,0) presented, acks ignored.
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);

        // Full throughput: six blocks back to back, then idle.
        for (int k = 0; k < 6; k++) begin
            sample();
            check_eq("i0_tbl", {16'd0, i0_mofs}, i0_tbl[k]);
            drive(1'b0, 4'b1111);
        end
        repeat (3) step(1'b0, 4'b1111);

        // Output stall; i1 keeps acking after its transfer (must be ignored).
        step(1'b1, 4'b0000);
        repeat (5) step(1'b0, 4'b0111);
        repeat (4) step(1'b0, 4'b1111);

        // Reset after three blocks restarts from (0,0).
        step(1'b1, 4'b0000);
        repeat (3) step(1'b0, 4'b1111);
        step(1'b1, 4'b1111);
        step(1'b0, 4'b0000);

        // Random independent acks until the grid completes.
        step(1'b1, 4'b0000);
        guard = 0;
        while (cur_blk() < NBLK && guard < 400) begin
            step(1'b0, 4'($urandom_range(0, 15)));
            guard++;
        end
        check_eq("random_complete", cur_blk(), NBLK);

        // After completion, toggling acks leaves everything idle.
        for (int k = 0; k < 20; k++) step(1'b0, (k % 2) ? 4'b1111 : 4'b0000);
        sample();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
